ex_hazard_ctrl: RTL and testbench

- Pipeline scheduler for the EX-stage ALU.
- Tracks in-flight destination registers in EX, MEM and WB, and detects load-use hazards; on a hazard it stalls IF/ID and inserts a bubble into ID/EX.
- Squashes wrong-path instructions when a branch or JR redirects the PC, and produces registered operand-forwarding selects for the ALU rs/rt inputs.
- Sits beside the ID/EX pipeline register; drives the stall/flush enables of the IF/ID and ID/EX registers and the EX operand muxes.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/sat_counter.sv | 27 ++
 rtl/ex_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants, forwarding-select and
// hazard-FSM encodings, and the shadow-slot record used by the hazard unit.
package pipe_pkg;

  // Register address width baked into the shadow slot; must match REG_AW.
  localparam int unsigned SLOT_AW = 5;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_LDW = 6'b001100;
  localparam logic [5:0] OP_STW = 6'b001101;
  localparam logic [5:0] OP_BZ  = 6'b001110;
  localparam logic [5:0] OP_BEQ = 6'b001111;
  localparam logic [5:0] OP_JR  = 6'b010000;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [SLOT_AW-1:0] dst;
    logic               is_load;
  } slot_t;

  // r0 is hardwired zero, so it never produces a hazard or a forward.
  function automatic logic slot_eligible(slot_t s);
    return s.valid & s.we & (s.dst != '0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   - clock
//   clear - synchronous clear (highest priority)
//   inc   - increment by one unless already all-ones
//   count - current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadows destination registers in EX/MEM/WB,
// stalls one cycle on load-use, squashes wrong-path work on redirect, and
// registers ALU operand-forwarding selects for the instruction entering EX.
//   clk, reset (sync, active-low)
//   id_*            - decoded ID-stage instruction
//   redirect_valid  - taken branch / JR resolved this cycle
//   stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex - pipeline controls
//   fwd_a_sel, fwd_b_sel - EX rs/rt source selects (fwd_sel_e encoding)
//   stall_cnt, flush_cnt - saturating statistics
module ex_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst_addr,
  input  logic              id_dst_we,
  input  logic              redirect_valid,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  slot_t     ex_q, mem_q, wb_q;
  slot_t     id_slot;
  fwd_sel_e  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  hz_state_e state_q, state_d;
  logic      load_use;
  logic      advance;

  // MEM/WB forwarding needs no load check, and WB is tracked for debug only.
  logic unused_shadow;
  assign unused_shadow = ^{wb_q, mem_q.is_load};

  function automatic fwd_sel_e fwd_pick(logic used, logic [REG_AW-1:0] src,
                                        slot_t older, slot_t oldest);
    if (!used) return FWD_RF;
    // A load in the older slot has no result yet; that case is a stall.
    if (slot_eligible(older) && !older.is_load && (older.dst == src)) return FWD_EXMEM;
    if (slot_eligible(oldest) && (oldest.dst == src)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = id_valid;
    id_slot.we      = id_dst_we;
    id_slot.dst     = id_dst_addr;
    id_slot.is_load = (id_op == OP_LDW);
  end

  assign load_use = slot_eligible(ex_q) && ex_q.is_load && id_valid &&
                    ((id_rs_used && (id_rs_addr == ex_q.dst)) ||
                     (id_rt_used && (id_rt_addr == ex_q.dst)));

  // Redirect wins over a simultaneous load-use hazard.
  assign flush_if_id  = redirect_valid;
  assign flush_id_ex  = redirect_valid;
  assign stall_if_id  = load_use && !redirect_valid;
  assign bubble_id_ex = load_use && !redirect_valid;
  assign advance      = !redirect_valid && !load_use;

  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (advance && id_valid) begin
      fwd_a_d = fwd_pick(id_rs_used, id_rs_addr, ex_q, mem_q);
      fwd_b_d = fwd_pick(id_rt_used, id_rt_addr, ex_q, mem_q);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     state_d = redirect_valid ? FLUSH : (load_use ? STALL : RUN);
      STALL:   state_d = redirect_valid ? FLUSH : RUN;
      FLUSH:   state_d = redirect_valid ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      state_q <= RUN;
    end else begin
      ex_q    <= advance ? id_slot : '0;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      state_q <= state_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clear (!reset),
    .inc   (stall_if_id),
    .count (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .clear (!reset),
    .inc   (redirect_valid),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [5:0]    id_op;
  logic [4:0]    id_rs_addr, id_rt_addr, id_dst_addr;
  logic          id_rs_used, id_rt_used, id_dst_we;
  logic          redirect_valid;
  logic          stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;
  exp_t sb[$];

  ex_hazard_ctrl #(
    .REG_AW (5),
    .OP_W   (6),
    .CNT_W  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_op          (id_op),
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .id_dst_addr    (id_dst_addr),
    .id_dst_we      (id_dst_we),
    .redirect_valid (redirect_valid),
    .stall_if_id    (stall_if_id),
    .bubble_id_ex   (bubble_id_ex),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic rsu, input logic [4:0] rt, input logic rtu,
                        input logic [4:0] dst, input logic we);
    id_valid = v; id_op = op; id_rs_addr = rs; id_rs_used = rsu;
    id_rt_addr = rt; id_rt_used = rtu; id_dst_addr = dst; id_dst_we = we;
  endtask

  task automatic idle();
    set_id(1'b0, 6'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; idle();
    step(); step();
    reset = 1'b1;
  endtask

  // Pops the expected selects for the instruction now in EX and compares.
  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got 0 entries want >=1");
      return;
    end
    e = sb.pop_front();
    total++;
    if (fwd_a_sel !== e.a) begin
      bad++; $display("FAIL %s fwd_a: got %b want %b", e.name, fwd_a_sel, e.a);
    end
    total++;
    if (fwd_b_sel !== e.b) begin
      bad++; $display("FAIL %s fwd_b: got %b want %b", e.name, fwd_b_sel, e.b);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall_if_id); end
    total++; if (bubble_id_ex !== 1'b0) begin bad++; $display("FAIL rst_bubble: got %b want 0", bubble_id_ex); end
    total++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
      bad++; $display("FAIL rst_flush: got %b%b want 00", flush_if_id, flush_id_ex);
    end
    total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin
      bad++; $display("FAIL rst_fwd: got %b%b want 0000", fwd_a_sel, fwd_b_sel);
    end
    total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 6'b001100, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1);   // LDW r3,[r1+4]
    sb.push_back('{"lu_ldw", 2'b00, 2'b00});
    step(); pop_cmp();
    set_id(1'b1, 6'b000000, 5'd3, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);   // ADD r5=r3+r2
    #1;
    total++; if (stall_if_id !== 1'b1 || bubble_id_ex !== 1'b1) begin
      bad++; $display("FAIL lu_stall: got %b%b want 11", stall_if_id, bubble_id_ex);
    end
    step();
    total++; if (stall_if_id !== 1'b0 || bubble_id_ex !== 1'b0) begin
      bad++; $display("FAIL lu_one_cycle: got %b%b want 00", stall_if_id, bubble_id_ex);
    end
    sb.push_back('{"lu_add", 2'b10, 2'b00});
    step(); pop_cmp();
    idle();
    total++; if (stall_cnt !== 8'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_ex_fwd();
    do_reset();
    set_id(1'b1, 6'b000000, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1);   // ADD r4
    sb.push_back('{"ex_add", 2'b00, 2'b00});
    step(); pop_cmp();
    set_id(1'b1, 6'b000001, 5'd4, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1);   // SUB r6=r4,r4
    #1;
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL ex_nostall: got %b want 0", stall_if_id); end
    sb.push_back('{"ex_sub", 2'b01, 2'b01});
    step(); pop_cmp();
    // rs not read; rt=r4 now one slot further back
    set_id(1'b1, 6'b000000, 5'd4, 1'b0, 5'd4, 1'b1, 5'd11, 1'b1);
    sb.push_back('{"ex_unused_rs", 2'b00, 2'b10});
    step(); pop_cmp();
    idle();
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL ex_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_mem_fwd();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] d;
      d = (k == 0) ? 5'd4 : 5'd0;
      do_reset();
      set_id(1'b1, 6'b000000, 5'd1, 1'b1, 5'd2, 1'b1, d, 1'b1);       // ADD rd
      sb.push_back('{"mem_add", 2'b00, 2'b00});
      step(); pop_cmp();
      set_id(1'b1, 6'b000011, 5'd8, 1'b1, 5'd9, 1'b1, 5'd7, 1'b1);    // OR r7
      sb.push_back('{"mem_or", 2'b00, 2'b00});
      step(); pop_cmp();
      set_id(1'b1, 6'b000010, d, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1);      // AND r10=rd&r9
      sb.push_back('{(k == 0) ? "mem_and_r4" : "mem_and_r0", (k == 0) ? 2'b10 : 2'b00, 2'b00});
      step(); pop_cmp();
      idle();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1'b1, 6'b001100, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1);
    step();
    set_id(1'b1, 6'b000000, 5'd3, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
    redirect_valid = 1'b1;
    #1;
    total++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
      bad++; $display("FAIL rd_flush: got %b%b want 11", flush_if_id, flush_id_ex);
    end
    total++; if (stall_if_id !== 1'b0 || bubble_id_ex !== 1'b0) begin
      bad++; $display("FAIL rd_nostall: got %b%b want 00", stall_if_id, bubble_id_ex);
    end
    sb.push_back('{"rd_squashed", 2'b00, 2'b00});
    step(); pop_cmp();
    redirect_valid = 1'b0; idle();
    #1;
    total++; if (flush_cnt !== 8'd1 || stall_cnt !== 8'd0) begin
      bad++; $display("FAIL rd_cnt: got %0d/%0d want 1/0", flush_cnt, stall_cnt);
    end
    redirect_valid = 1'b1; step(); step();
    redirect_valid = 1'b0; #1;
    total++; if (flush_cnt !== 8'd3) begin bad++; $display("FAIL rd_b2b: got %0d want 3", flush_cnt); end
  endtask

  task automatic test_saturation();
    int n;
    n = 0;
    do_reset();
    // LDW r3 reading r3: stalls on every other cycle.
    set_id(1'b1, 6'b001100, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1);
    #1;
    for (int i = 0; i < 600; i++) begin
      if (stall_if_id) n++;
      step();
    end
    idle();
    #1;
    total++; if (stall_cnt !== ((n > 255) ? 8'hFF : 8'(n))) begin
      bad++; $display("FAIL sat_stall: got %0d want %0d (seen %0d)", stall_cnt, (n > 255) ? 255 : n, n);
    end
    redirect_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    redirect_valid = 1'b0;
    #1;
    total++; if (flush_cnt !== 8'hFF) begin bad++; $display("FAIL sat_flush: got %0d want 255", flush_cnt); end
    total++; if (stall_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hold: got %0d want 255", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 6'b001100, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1);
    step();
    set_id(1'b1, 6'b000000, 5'd3, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
    #1;
    total++; if (stall_if_id !== 1'b1) begin bad++; $display("FAIL ms_pre: got %b want 1", stall_if_id); end
    redirect_valid = 1'b1;  // also mid-flush
    reset = 1'b0;
    step();
    reset = 1'b1; redirect_valid = 1'b0;
    #1;
    total++; if ({stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex} !== 4'b0) begin
      bad++; $display("FAIL ms_ctrl: got %b%b%b%b want 0000", stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex);
    end
    total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++; $display("FAIL ms_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    sb.push_back('{"ms_first", 2'b00, 2'b00});
    step(); pop_cmp();
    idle();
  endtask

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_ex_fwd();
    test_mem_fwd();
    test_redirect();
    test_saturation();
    test_reset_mid_stall();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
